ddr3_init_sequencer: RTL
========================

Name: ddr3_init_sequencer

Overview:
- Hardware Wishbone master that performs the DDR3 power-up/initialisation sequence by writing the DFII (DFI injector) CSRs.
- Sequence: reset/CKE control, MR2, MR3, MR1, MR0, ZQCL, then handover of the PHY to the hardware controller.
- Replaces the software/UART-driven init. Sits beside the UART bridge on the SoC CSR bus, as a second master through the existing interconnect arbiter.

Parameters:
- DFII_BASE, 30'h2400: word address of the DFII CONTROL register (byte address 0x9000).
- MR0_VAL, 14'h320: MR0 address-field value.
- MR1_VAL, 14'h006: MR1 value.
- MR2_VAL, 14'h200: MR2 value.
- MR3_VAL, 14'h000: MR3 value.
- T_RESET, 50000: wait cycles after the RESET_N-only (CKE low) write.
- T_CKE, 50000: wait cycles after CKE is asserted.
- T_MRD, 8: wait cycles after each MR2/MR3/MR1 issue.
- T_MOD, 200: wait cycles after the MR0 issue.
- T_ZQINIT, 200: wait cycles after the ZQCL issue.
- ACK_TIMEOUT, 1023: watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle pulse; begins the sequence.
- busy  out  1  sequence in progress.
- done  out  1  sequence completed; sticky until the next start.
- error  out  1  bus error or timeout; sticky until the next start.
- step  out  5  index of the current or last write, 0..25.
- wb_cyc  out  1  Wishbone cycle.
- wb_stb  out  1  Wishbone strobe.
- wb_we  out  1  write enable; always 1 while wb_cyc is high.
- wb_adr  out  30  word address.
- wb_dat_w  out  32  write data.
- wb_sel  out  4  byte select; constant 4'hF.
- wb_ack  in  1  slave acknowledge.
- wb_err  in  1  slave error.

Behaviour:
- Register offsets from DFII_BASE: CONTROL +0, COMMAND +1, ISSUE +2, ADDRESS +3, BADDRESS +4.
- Step table (offset=data, post-delay):
  - 0: CTRL=0x0E
  - 1: ADDR=0
  - 2: BADDR=0
  - 3: CTRL=0x0C, T_RESET
  - 4: CTRL=0x0E, T_CKE
  - 5-8: ADDR=MR2_VAL, BADDR=2, CMD=0x0F, ISSUE=1 with T_MRD
  - 9-12: same for MR3, BADDR=3
  - 13-16: same for MR1, BADDR=1
  - 17-20: same for MR0, BADDR=0, ISSUE followed by T_MOD
  - 21-24: ADDR=0x400, BADDR=0, CMD=0x03, ISSUE=1 with T_ZQINIT
  - 25: CTRL=0x01
  - All other steps have delay 0.
- Data is zero-extended to 32 bits.
- FSM states: IDLE, WRITE, WAIT, DONE, ERROR.
- IDLE/DONE/ERROR, start=1:
  - Next cycle: WRITE, step=0, busy=1; done and error cleared.
  - wb_cyc, wb_stb, wb_adr and wb_dat_w are all registered and valid in that same cycle.
- WRITE:
  - Hold cyc/stb/adr/dat stable until wb_ack or wb_err.
  - On ack: the next cycle drops cyc/stb and enters WAIT with the counter loaded with the step delay.
  - If wb_err and wb_ack are both high, wb_err wins.
  - On wb_err: the next cycle drops cyc/stb, enters ERROR, sets error=1 and busy=0; step holds the failing index.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, advance: step+1 and WRITE, or DONE after step 25.
  - An ack in cycle N therefore gives the next stb rising in cycle N+D+2, with D the post-delay.
- DONE: done=1, busy=0, step=25.
- Ignored inputs:
  - start while busy.
  - wb_ack/wb_err while wb_cyc=0.
- Counter width: 16 bits minimum. Delay parameters are 1..65535 or 0.
- Reset, asserted at any time, including mid-cycle or mid-wait:
  - All outputs go to 0 immediately; step=0; state IDLE.
  - No partial-cycle recovery.

Optional Feature:
- Macro: DDR3_INIT_ACK_TIMEOUT_EN.
- Defined:
  - In WRITE, a watchdog counts cycles without ack/err.
  - When the count reaches ACK_TIMEOUT, the next cycle drops cyc/stb and enters ERROR with error=1 (same as wb_err).
  - The watchdog is cleared on every new write.
- Undefined: no watchdog; WRITE waits indefinitely; ACK_TIMEOUT is unused.

Test Plan:
- Zero-wait slave (ack the cycle after stb), all delays=2, start pulse:
  - Exactly 26 writes observed.
  - Write 0: adr 0x2400, dat 0x0E. Write 3: 0x2400/0x0C. Write 5: 0x2403/0x200. Write 25: 0x2400/0x01.
  - done=1, busy=0, step=25.
- T_RESET=10: ack of write 3 in cycle N, stb of write 4 rises in cycle N+12. Writes 0→1 (delay 0): stb rises at N'+2.
- Slave inserts 5 wait states per write: cyc/stb/adr/dat stable for all 6 cycles of each write; final result identical to the first test.
- wb_err asserted on write 7 → error=1, busy=0, step=7, cyc=0 next cycle. A new start restarts from step 0 and clears error.
- start pulsed at step 10 → ignored. rst asserted during the T_CKE wait → all outputs 0 at once, FSM IDLE; a later start restarts cleanly.
- With DDR3_INIT_ACK_TIMEOUT_EN, ACK_TIMEOUT=16, slave never acks write 0 → error=1 after 16 cycles, cyc dropped. Without the macro, cyc is still high after 1000 cycles.

Source files
------------

// File: rtl/ddr3_init_sequencer.sv
// Wishbone master that replays the DDR3 power-up/MR/ZQCL sequence into the DFII CSRs.
// Define DDR3_INIT_ACK_TIMEOUT_EN to add an ack watchdog that aborts a stalled write.
`timescale 1ns/1ps
module ddr3_init_sequencer #(
  parameter logic [29:0] DFII_BASE   = 30'h2400,
  parameter logic [13:0] MR0_VAL     = 14'h320,
  parameter logic [13:0] MR1_VAL     = 14'h006,
  parameter logic [13:0] MR2_VAL     = 14'h200,
  parameter logic [13:0] MR3_VAL     = 14'h000,
  parameter int unsigned T_RESET     = 50000,
  parameter int unsigned T_CKE       = 50000,
  parameter int unsigned T_MRD       = 8,
  parameter int unsigned T_MOD       = 200,
  parameter int unsigned T_ZQINIT    = 200,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [4:0]  step,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [29:0] wb_adr,
  output logic [31:0] wb_dat_w,
  output logic [3:0]  wb_sel,
  input  logic        wb_ack,
  input  logic        wb_err
);

  localparam logic [2:0] OFF_CTRL  = 3'd0;
  localparam logic [2:0] OFF_CMD   = 3'd1;
  localparam logic [2:0] OFF_ISSUE = 3'd2;
  localparam logic [2:0] OFF_ADDR  = 3'd3;
  localparam logic [2:0] OFF_BADDR = 3'd4;
  localparam logic [4:0] LAST_STEP = 5'd25;

  typedef enum logic [2:0] {IDLE, WRITE, WAIT, DONE, ERROR} state_t;

  typedef struct packed {
    logic [2:0]  off;
    logic [13:0] data;
    logic [15:0] delay;
  } entry_t;

  // Steps 5..24 are five groups of ADDR/BADDR/CMD/ISSUE; only the issue write carries a delay.
  function automatic entry_t step_entry(input logic [4:0] idx);
    entry_t      e;
    logic [4:0]  rel;
    logic [13:0] mr_val;
    logic [13:0] bank;
    logic [13:0] cmd;
    logic [15:0] post;
    e      = '0;
    rel    = idx - 5'd5;
    mr_val = '0;
    bank   = '0;
    cmd    = 14'h00F;
    post   = '0;
    case (rel[4:2])
      3'd0: begin mr_val = MR2_VAL; bank = 14'd2; post = 16'(T_MRD); end
      3'd1: begin mr_val = MR3_VAL; bank = 14'd3; post = 16'(T_MRD); end
      3'd2: begin mr_val = MR1_VAL; bank = 14'd1; post = 16'(T_MRD); end
      3'd3: begin mr_val = MR0_VAL; bank = 14'd0; post = 16'(T_MOD); end
      3'd4: begin mr_val = 14'h400; bank = 14'd0; cmd = 14'h003; post = 16'(T_ZQINIT); end
      default: ;
    endcase
    case (idx)
      5'd0:  begin e.off = OFF_CTRL; e.data = 14'h00E; end
      5'd1:  e.off = OFF_ADDR;
      5'd2:  e.off = OFF_BADDR;
      5'd3:  begin e.off = OFF_CTRL; e.data = 14'h00C; e.delay = 16'(T_RESET); end
      5'd4:  begin e.off = OFF_CTRL; e.data = 14'h00E; e.delay = 16'(T_CKE); end
      5'd25: begin e.off = OFF_CTRL; e.data = 14'h001; end
      default: begin
        if (idx < LAST_STEP) begin
          case (rel[1:0])
            2'd0: begin e.off = OFF_ADDR;  e.data = mr_val; end
            2'd1: begin e.off = OFF_BADDR; e.data = bank; end
            2'd2: begin e.off = OFF_CMD;   e.data = cmd; end
            2'd3: begin e.off = OFF_ISSUE; e.data = 14'd1; e.delay = post; end
          endcase
        end
      end
    endcase
    return e;
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  step_q, step_d;
  logic [15:0] cnt_q, cnt_d;
  logic        cyc_q, cyc_d;
  logic [29:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic [4:0]  load_idx;
  entry_t      load_e;
  entry_t      cur_e;
  logic [29:0] load_adr;
  logic [31:0] load_dat;

  // From IDLE/DONE/ERROR the next write is always step 0; from WAIT it is the following step.
  assign load_idx = (state_q == WAIT) ? step_q + 5'd1 : 5'd0;
  assign load_e   = step_entry(load_idx);
  assign cur_e    = step_entry(step_q);
  assign load_adr = DFII_BASE + {27'd0, load_e.off};
  assign load_dat = {18'd0, load_e.data};

  logic unused_entry_bits;
  assign unused_entry_bits = ^{cur_e.off, cur_e.data, load_e.delay};

`ifdef DDR3_INIT_ACK_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(ACK_TIMEOUT - 1);
  logic [15:0] wdog_q, wdog_d;
`else
  logic unused_ack_timeout;
  assign unused_ack_timeout = ^ACK_TIMEOUT;
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
`ifdef DDR3_INIT_ACK_TIMEOUT_EN
    wdog_d  = wdog_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = WRITE;
          step_d  = '0;
          cyc_d   = 1'b1;
          adr_d   = load_adr;
          dat_d   = load_dat;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
`ifdef DDR3_INIT_ACK_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end
      end
      WRITE: begin
        // A simultaneous err and ack is treated as an error.
        if (wb_err) begin
          state_d = ERROR;
          cyc_d   = 1'b0;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else if (wb_ack) begin
          state_d = WAIT;
          cyc_d   = 1'b0;
          cnt_d   = cur_e.delay;
        end
`ifdef DDR3_INIT_ACK_TIMEOUT_EN
        else if (wdog_q == WDOG_LAST) begin
          state_d = ERROR;
          cyc_d   = 1'b0;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      WAIT: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (step_q == LAST_STEP) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = WRITE;
          step_d  = step_q + 5'd1;
          cyc_d   = 1'b1;
          adr_d   = load_adr;
          dat_d   = load_dat;
`ifdef DDR3_INIT_ACK_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef DDR3_INIT_ACK_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
`ifdef DDR3_INIT_ACK_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign step     = step_q;
  assign wb_cyc   = cyc_q;
  assign wb_stb   = cyc_q;
  assign wb_we    = cyc_q;
  assign wb_adr   = adr_q;
  assign wb_dat_w = dat_q;
  assign wb_sel   = 4'hF;

endmodule
